// File: rtl/approx_mul_pipe_if.sv
// approx_mul_pipe_if
//   Operand/result handshake bundle for approx_mul_pipe.
//   Input side : in_valid, in_ready, x, y, approx, tag_in
//   Output side: out_valid, out_ready, z, err, tag_out
//   master = producer/consumer side, slave = multiplier side.
interface approx_mul_pipe_if #(
  parameter int W     = 8,
  parameter int TAG_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       x;
  logic [W-1:0]       y;
  logic               approx;
  logic [TAG_W-1:0]   tag_in;
  logic               out_valid;
  logic               out_ready;
  logic [2*W-1:0]     z;
  logic [2*W-1:0]     err;
  logic [TAG_W-1:0]   tag_out;

  modport master (
    output in_valid, x, y, approx, tag_in, out_ready,
    input  in_ready, out_valid, z, err, tag_out
  );

  modport slave (
    input  in_valid, x, y, approx, tag_in, out_ready,
    output in_ready, out_valid, z, err, tag_out
  );
endinterface

// File: rtl/approx_mul_pipe.sv
// approx_mul_pipe
//   Two-stage pipelined unsigned W x W multiplier. Each transaction selects
//   the exact product or a truncated-row approximation in which the low L
//   multiplier rows are replaced by an OR-compressed compensation vector.
//   Every result carries err = exact - returned product.
// Ports
//   clk    : clock, all state on rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : approx_mul_pipe_if.slave
//            in_valid/in_ready/x/y/approx/tag_in   operand handshake
//            out_valid/out_ready/z/err/tag_out     result handshake
module approx_mul_pipe #(
  parameter int W     = 8,
  parameter int L     = 2,
  parameter int TAG_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  approx_mul_pipe_if.slave bus
);

  localparam int PW = 2 * W;
  localparam logic [W-1:0] LO_MASK = W'((1 << L) - 1);

  // Compensation for the dropped rows: column c in W-1 .. W+L-2 is the OR of
  // every dropped partial-product bit x[r] & y[c-r] that lands in it.
  function automatic logic [PW-1:0] comp_vec(input logic [W-1:0] xv,
                                             input logic [W-1:0] yv);
    logic [PW-1:0] acc;
    logic [PW-1:0] one;
    logic [W-1:0]  xs;
    logic [W-1:0]  ys;
    acc = '0;
    one = PW'(1);
    for (int c = 0; c < PW; c++) begin
      for (int r = 0; r < L; r++) begin
        if ((c >= W - 1) && (c <= W + L - 2) && (c - r < W)) begin
          xs = xv >> r;
          ys = yv >> (c - r);
          if (xs[0] && ys[0]) acc = acc | (one << c);
        end
      end
    end
    return acc;
  endfunction

  // ---- stage p0: partial terms straight from the operands ----
  logic [PW-1:0] hi_p0;
  logic [PW-1:0] lo_p0;
  logic [PW-1:0] comp_p0;

  always_comb begin
    hi_p0   = {{W{1'b0}}, bus.y} * {{W{1'b0}}, (bus.x >> L)};
    lo_p0   = {{W{1'b0}}, bus.y} * {{W{1'b0}}, (bus.x & LO_MASK)};
    comp_p0 = comp_vec(bus.x, bus.y);
  end

  // ---- stage p1 registers ----
  logic               vld_p1_q, vld_p1_d;
  logic [PW-1:0]      hi_p1_q;
  logic [PW-1:0]      lo_p1_q;
  logic [PW-1:0]      comp_p1_q;
  logic               apx_p1_q;
  logic [TAG_W-1:0]   tag_p1_q;

  // ---- stage p2 registers ----
  logic               vld_p2_q, vld_p2_d;
  logic [PW-1:0]      z_p2_q, z_p2_d;
  logic [PW-1:0]      err_p2_q, err_p2_d;
  logic [TAG_W-1:0]   tag_p2_q, tag_p2_d;

  logic          s2_en;
  logic          accept;
  logic          advance;
  logic [PW-1:0] exact_p1;
  logic [PW-1:0] approx_p1;

  // No skid buffer: in_ready depends combinationally on out_ready.
  assign s2_en        = !vld_p2_q || bus.out_ready;
  assign bus.in_ready = !vld_p1_q || s2_en;
  assign accept       = bus.in_valid && bus.in_ready;
  assign advance      = vld_p1_q && s2_en;

  always_comb begin
    vld_p1_d = vld_p1_q;
    if (accept)       vld_p1_d = 1'b1;
    else if (advance) vld_p1_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1_q <= 1'b0;
    else        vld_p1_q <= vld_p1_d;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      hi_p1_q   <= hi_p0;
      lo_p1_q   <= lo_p0;
      comp_p1_q <= comp_p0;
      apx_p1_q  <= bus.approx;
      tag_p1_q  <= bus.tag_in;
    end
  end

  // ---- stage p1 -> p2: recombine shifted high rows with low term or compensation ----
  always_comb begin
    exact_p1  = (hi_p1_q << L) + lo_p1_q;
    approx_p1 = (hi_p1_q << L) + comp_p1_q;
    vld_p2_d  = vld_p2_q;
    z_p2_d    = z_p2_q;
    err_p2_d  = err_p2_q;
    tag_p2_d  = tag_p2_q;
    if (s2_en) vld_p2_d = vld_p1_q;
    if (advance) begin
      z_p2_d   = apx_p1_q ? approx_p1 : exact_p1;
      err_p2_d = exact_p1 - z_p2_d;
      tag_p2_d = tag_p1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2_q <= 1'b0;
      z_p2_q   <= '0;
      err_p2_q <= '0;
      tag_p2_q <= '0;
    end else begin
      vld_p2_q <= vld_p2_d;
      z_p2_q   <= z_p2_d;
      err_p2_q <= err_p2_d;
      tag_p2_q <= tag_p2_d;
    end
  end

  assign bus.out_valid = vld_p2_q;
  assign bus.z         = z_p2_q;
  assign bus.err       = err_p2_q;
  assign bus.tag_out   = tag_p2_q;

endmodule

// File: tb/tb_approx_mul_pipe.sv
module tb_approx_mul_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  approx_mul_pipe_if #(.W(8), .TAG_W(4)) bus ();
  approx_mul_pipe #(.W(8), .L(2), .TAG_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  approx_mul_pipe_if #(.W(4), .TAG_W(4)) b4_0 ();
  approx_mul_pipe_if #(.W(4), .TAG_W(4)) b4_1 ();
  approx_mul_pipe_if #(.W(4), .TAG_W(4)) b4_2 ();
  approx_mul_pipe_if #(.W(4), .TAG_W(4)) b4_3 ();
  approx_mul_pipe #(.W(4), .L(0), .TAG_W(4)) dut4_0 (.clk(clk), .rst_n(rst_n), .bus(b4_0));
  approx_mul_pipe #(.W(4), .L(1), .TAG_W(4)) dut4_1 (.clk(clk), .rst_n(rst_n), .bus(b4_1));
  approx_mul_pipe #(.W(4), .L(2), .TAG_W(4)) dut4_2 (.clk(clk), .rst_n(rst_n), .bus(b4_2));
  approx_mul_pipe #(.W(4), .L(3), .TAG_W(4)) dut4_3 (.clk(clk), .rst_n(rst_n), .bus(b4_3));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [15:0] z;
    logic [15:0] err;
    logic [3:0]  tag;
  } exp_t;

  typedef struct {
    logic [3:0][7:0] z;
    logic [3:0][7:0] err;
    logic [3:0][7:0] ex;
  } exp4_t;

  exp_t  sb[$];
  exp4_t sb4[$];
  int    acc_cyc[$];
  int    pop_cyc[$];

  bit          use_const = 1'b0;
  logic [15:0] cz, ce;

  // Reference: exact product, truncated-row product with OR compensation.
  function automatic void model(input int w, input int l,
                                input longint unsigned xv, input longint unsigned yv,
                                input bit ap, output longint unsigned zo,
                                output longint unsigned eo, output longint unsigned ex);
    longint unsigned e, hi, c, a;
    e  = xv * yv;
    hi = yv * (xv >> l);
    c  = 0;
    for (int col = w - 1; col <= w + l - 2; col++)
      for (int r = 0; r < l; r++)
        if ((col - r) < w && ((xv >> r) & 1) == 1 && ((yv >> (col - r)) & 1) == 1)
          c = c | (64'd1 << col);
    a  = (hi << l) + c;
    zo = ap ? a : e;
    eo = e - zo;
    ex = e;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  task automatic drv(input bit v, input logic [7:0] xv, input logic [7:0] yv,
                     input bit ap, input logic [3:0] t);
    bus.in_valid = v;
    bus.x        = xv;
    bus.y        = yv;
    bus.approx   = ap;
    bus.tag_in   = t;
  endtask

  // Called 1 time unit after an edge with inputs already applied.
  task automatic cycle();
    exp_t e;
    longint unsigned mz, me, mx;
    #1;
    if (bus.in_valid && bus.in_ready) begin
      if (use_const) begin
        e.z = cz; e.err = ce;
      end else begin
        model(8, 2, longint'(bus.x), longint'(bus.y), bus.approx, mz, me, mx);
        e.z = mz[15:0]; e.err = me[15:0];
      end
      e.tag = bus.tag_in;
      sb.push_back(e);
      acc_cyc.push_back(cyc);
    end
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 64'(bus.out_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("z", 64'(bus.z), 64'(e.z));
        chk("err", 64'(bus.err), 64'(e.err));
        chk("tag", 64'(bus.tag_out), 64'(e.tag));
        pop_cyc.push_back(cyc);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic dir(input logic [7:0] xv, input logic [7:0] yv, input bit ap,
                     input logic [3:0] t, input logic [15:0] ez, input logic [15:0] ee);
    use_const = 1'b1;
    cz = ez;
    ce = ee;
    drv(1'b1, xv, yv, ap, t);
    cycle();
    use_const = 1'b0;
  endtask

  function automatic logic [7:0] z4(input int l);
    case (l)
      0: return b4_0.z;
      1: return b4_1.z;
      2: return b4_2.z;
      default: return b4_3.z;
    endcase
  endfunction

  function automatic logic [7:0] err4(input int l);
    case (l)
      0: return b4_0.err;
      1: return b4_1.err;
      2: return b4_2.err;
      default: return b4_3.err;
    endcase
  endfunction

  function automatic logic ov4(input int l);
    case (l)
      0: return b4_0.out_valid;
      1: return b4_1.out_valid;
      2: return b4_2.out_valid;
      default: return b4_3.out_valid;
    endcase
  endfunction

  task automatic set4(input bit v, input logic [3:0] xv, input logic [3:0] yv, input bit ap);
    b4_0.in_valid = v; b4_0.x = xv; b4_0.y = yv; b4_0.approx = ap; b4_0.tag_in = xv;
    b4_1.in_valid = v; b4_1.x = xv; b4_1.y = yv; b4_1.approx = ap; b4_1.tag_in = xv;
    b4_2.in_valid = v; b4_2.x = xv; b4_2.y = yv; b4_2.approx = ap; b4_2.tag_in = xv;
    b4_3.in_valid = v; b4_3.x = xv; b4_3.y = yv; b4_3.approx = ap; b4_3.tag_in = xv;
  endtask

  task automatic cycle4();
    exp4_t e;
    longint unsigned mz, me, mx;
    logic [7:0] oz, oe;
    #1;
    if (ov4(0)) begin
      if (sb4.size() == 0) begin
        chk("w4_unexpected_out", 64'(ov4(0)), 64'd0);
      end else begin
        e = sb4.pop_front();
        for (int l = 0; l < 4; l++) begin
          oz = z4(l);
          oe = err4(l);
          chk("w4_valid", 64'(ov4(l)), 64'd1);
          chk("w4_z", 64'(oz), 64'(e.z[l]));
          chk("w4_err", 64'(oe), 64'(e.err[l]));
          chk("w4_sum", 64'(oz + oe), 64'(e.ex[l]));
          chk("w4_le", 64'(oz <= e.ex[l]), 64'd1);
        end
      end
    end
    if (b4_0.in_valid && b4_0.in_ready && b4_3.in_ready) begin
      for (int l = 0; l < 4; l++) begin
        model(4, l, longint'(b4_0.x), longint'(b4_0.y), b4_0.approx, mz, me, mx);
        e.z[l] = mz[7:0]; e.err[l] = me[7:0]; e.ex[l] = mx[7:0];
      end
      sb4.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic [15:0] z_hold;
    logic [3:0]  tag_hold;

    rst_n = 1'b0;
    drv(1'b0, 8'h00, 8'h00, 1'b0, 4'h0);
    bus.out_ready = 1'b1;
    set4(1'b0, 4'h0, 4'h0, 1'b0);
    b4_0.out_ready = 1'b1; b4_1.out_ready = 1'b1;
    b4_2.out_ready = 1'b1; b4_3.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_z", 64'(bus.z), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_tag", 64'(bus.tag_out), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    rst_n = 1'b1;

    // Directed vectors, W=8 L=2
    dir(8'hFF, 8'hFF, 1'b1, 4'h1, 16'd64644, 16'd381);
    dir(8'hFF, 8'hFF, 1'b0, 4'h2, 16'd65025, 16'd0);
    dir(8'h02, 8'hC0, 1'b1, 4'h3, 16'd384, 16'd0);
    dir(8'h01, 8'hC0, 1'b1, 4'h4, 16'd128, 16'd64);
    dir(8'h03, 8'h01, 1'b1, 4'h5, 16'd0, 16'd3);
    drv(1'b0, 8'h00, 8'h00, 1'b0, 4'h0);
    repeat (3) cycle();
    chk("dir_drain", 64'(sb.size()), 64'd0);

    // Back-to-back random stream
    acc_cyc.delete();
    pop_cyc.delete();
    for (int i = 0; i < 16; i++) begin
      drv(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 4'(i));
      cycle();
    end
    drv(1'b0, 8'h00, 8'h00, 1'b0, 4'h0);
    repeat (4) cycle();
    chk("burst_accepts", 64'(acc_cyc.size()), 64'd16);
    chk("burst_pops", 64'(pop_cyc.size()), 64'd16);
    chk("burst_latency", 64'(pop_cyc[0] - acc_cyc[0]), 64'd2);
    chk("burst_contiguous", 64'(pop_cyc[15] - pop_cyc[0]), 64'd15);

    // Backpressure: out_ready low for 5 cycles with continuous in_valid
    acc_cyc.delete();
    pop_cyc.delete();
    bus.out_ready = 1'b0;
    z_hold   = '0;
    tag_hold = '0;
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 4'(8 + i));
      cycle();
      if (i == 2) begin
        z_hold   = bus.z;
        tag_hold = bus.tag_out;
      end
    end
    #1;
    chk("stall_accepts", 64'(acc_cyc.size()), 64'd2);
    chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
    chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
    chk("stall_z_stable", 64'(bus.z), 64'(z_hold));
    chk("stall_tag_stable", 64'(bus.tag_out), 64'(tag_hold));
    bus.out_ready = 1'b1;
    drv(1'b0, 8'h00, 8'h00, 1'b0, 4'h0);
    repeat (4) cycle();
    chk("stall_drain_pops", 64'(pop_cyc.size()), 64'd2);
    chk("stall_drain_empty", 64'(sb.size()), 64'd0);

    // Reset while both stages are full
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 8'h5A, 8'hA5, 1'b1, 4'hC);
      cycle();
    end
    drv(1'b0, 8'h00, 8'h00, 1'b0, 4'h0);
    #2;
    chk("prerst_out_valid", 64'(bus.out_valid), 64'd1);
    chk("prerst_in_ready", 64'(bus.in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("async_rst_z", 64'(bus.z), 64'd0);
    chk("async_rst_err", 64'(bus.err), 64'd0);
    chk("async_rst_tag", 64'(bus.tag_out), 64'd0);
    chk("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
    sb.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc.delete();
    pop_cyc.delete();
    bus.out_ready = 1'b1;
    drv(1'b1, 8'h12, 8'h34, 1'b0, 4'h7);
    cycle();
    drv(1'b0, 8'h00, 8'h00, 1'b0, 4'h0);
    repeat (3) cycle();
    chk("postrst_pops", 64'(pop_cyc.size()), 64'd1);
    chk("postrst_latency", 64'(pop_cyc[0] - acc_cyc[0]), 64'd2);

    // Exhaustive W=4, L=0..3, both modes
    for (int i = 0; i < 512; i++) begin
      set4(1'b1, 4'(i), 4'(i >> 4), 1'(i >> 8));
      cycle4();
    end
    set4(1'b0, 4'h0, 4'h0, 1'b0);
    repeat (3) cycle4();
    chk("w4_drain", 64'(sb4.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
